cla_4bit: RTL and testbench
===========================

CLA_4BIT -- requirements
Module: cla_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal values are positive multiples of 4.
REQ-002 SHALL have parameter GROUP, fixed at 4, lookahead group size in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH bits: unsigned addend.
REQ-006 SHALL have port b, input, WIDTH bits: unsigned addend.
REQ-007 SHALL have port sum, output, WIDTH bits: registered low WIDTH bits of a+b.
REQ-008 SHALL have port cout, output, 1 bit: registered carry out of the MSB of a+b.
REQ-009 SHALL use the port order clk, rst_n, a, b, sum, cout.
REQ-010 SHALL have no carry-in port; carry into bit 0 is constant 0.

Function
REQ-011 SHALL compute per-bit generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i].
REQ-012 SHALL compute carries within each 4-bit group from the two-level lookahead equations:
- c1=g0|p0c0
- c2=g1|p1g0|p1p0c0
- c3=g2|p2g1|p2p1g0|p2p1p0c0
- c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0
REQ-013 SHALL NOT ripple carries from bit to bit within a group.
REQ-014 SHALL produce group generate G and group propagate P for each group.
REQ-015 SHALL, when WIDTH>4, compute the inter-group carries with a second-level lookahead unit built on the same equations over G/P, not by group-to-group ripple.
REQ-016 SHALL compute sum bit s[i]=p[i]^c[i].
REQ-017 SHALL compute the combinational carry out as the carry out of the top group.
REQ-018 SHALL register {cout,sum} on every rising clk edge when rst_n=1.
REQ-019 SHALL give a latency of exactly 1 clock: operands stable at rising edge N appear on sum/cout immediately after edge N.
REQ-020 SHALL hold outputs constant between rising edges regardless of input changes, including input changes on the falling edge.
REQ-021 SHALL produce {cout,sum} equal to a+b modulo 2^(WIDTH+1) for every operand pair, with no exceptions.
REQ-022 SHALL wrap modulo 2^WIDTH on overflow, with sum = low bits and cout=1 (e.g. 15+1 -> sum=0, cout=1).
REQ-023 SHALL have no handshake, enable or valid signal; every edge samples new operands.
REQ-024 SHALL leave outputs unspecified between power-up and the first reset edge.

Reset
REQ-025 SHALL clear sum to 0 and cout to 0 on a rising clk edge while rst_n=0.
REQ-026 SHALL give reset priority over the addition result on that edge.
REQ-027 SHALL have rst_n take effect only at clock edges: asserting or deasserting it between edges changes nothing until the next rising edge.
REQ-028 SHALL, on deassertion mid-operation, register the sum of the then-current a,b at the first rising edge with rst_n=1.

Verification
REQ-029 SHALL cover reset: rst_n=0, a=9, b=9, one edge -> sum=0, cout=0; rst_n=1 at next edge -> sum=2, cout=1.
REQ-030 SHALL cover the exhaustive sweep: all 256 (a,b) pairs for WIDTH=4, one per cycle -> each result matches a+b one cycle later.
REQ-031 SHALL cover the carry chain: a=15, b=1 -> sum=0, cout=1; a=15, b=15 -> sum=14, cout=1; a=8, b=7 -> sum=15, cout=0.
REQ-032 SHALL cover latency and hold: operands changed on the falling edge (a=3, b=4 replaced by a=5, b=6) -> outputs show 7 until the next rising edge, then 11.
REQ-033 SHALL cover reset mid-stream: rst_n=0 for one edge during the sweep -> that cycle outputs 0 and the next cycle resumes correct sums.
REQ-034 SHALL cover WIDTH=8: a=255, b=1 -> sum=0, cout=1; a=0x0F, b=0x01 -> sum=0x10, cout=0 (exercises the inter-group carry).

Source files
------------

// File: rtl/cla_4bit.sv
// Registered carry-lookahead adder: 4-bit groups with explicit two-level lookahead,
// plus a second-level lookahead over group generate/propagate when WIDTH > 4.
module cla_4bit #(
    parameter int WIDTH = 4,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_s;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP:0]    w_gc;
    logic             w_term;
    logic             w_cin;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_g   = a & b;
    assign w_p   = a ^ b;
    assign w_cin = 1'b0;

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        logic [3:0] w_gl;
        logic [3:0] w_pl;
        logic       w_c0;

        assign w_gl = w_g[GROUP*j +: GROUP];
        assign w_pl = w_p[GROUP*j +: GROUP];
        assign w_c0 = w_gc[j];

        // Each carry is a flat sum of products of the group carry-in; no ripple.
        assign w_c[GROUP*j]     = w_c0;
        assign w_c[GROUP*j + 1] = w_gl[0] | (w_pl[0] & w_c0);
        assign w_c[GROUP*j + 2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_c0);
        assign w_c[GROUP*j + 3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                                | (w_pl[2] & w_pl[1] & w_pl[0] & w_c0);

        assign w_gg[j] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                       | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
        assign w_gp[j] = &w_pl;
    end

    // Second-level lookahead: carry into group jj is OR over k<jj of G[k]&P[k+1..jj-1],
    // plus the all-propagate term on the constant carry-in.
    always_comb begin
        w_gc   = '0;
        w_term = 1'b0;
        w_gc[0] = w_cin;
        for (int jj = 1; jj <= NGRP; jj++) begin
            w_term = w_cin;
            for (int m = 0; m < jj; m++) begin
                w_term = w_term & w_gp[m];
            end
            w_gc[jj] = w_term;
            for (int k = 0; k < jj; k++) begin
                w_term = w_gg[k];
                for (int m = k + 1; m < jj; m++) begin
                    w_term = w_term & w_gp[m];
                end
                w_gc[jj] = w_gc[jj] | w_term;
            end
        end
    end

    assign w_s = w_p ^ w_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_gc[NGRP];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_cla_4bit.sv
// Scoreboard bench for cla_4bit: a 4-bit and an 8-bit instance share clock and reset.
module tb_cla_4bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a4, b4, sum4;
    logic       cout4;
    logic [7:0] a8, b8, sum8;
    logic       cout8;

    logic [4:0] q4[$];
    logic [8:0] q8[$];
    logic [4:0] last4;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    cla_4bit #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a4),
        .b     (b4),
        .sum   (sum4),
        .cout  (cout4)
    );

    cla_4bit #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .sum   (sum8),
        .cout  (cout8)
    );

    task automatic check4(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input bit with8);
        logic [4:0] e4;
        logic [8:0] e8;
        if (q4.size() == 0) begin
            check4({tag, "_q4empty"}, 5'h1f, 5'h00);
        end else begin
            e4 = q4.pop_front();
            last4 = e4;
            check4(tag, {cout4, sum4}, e4);
        end
        if (q8.size() == 0) begin
            check8({tag, "_q8empty"}, 9'h1ff, 9'h000);
        end else begin
            e8 = q8.pop_front();
            if (with8) check8({tag, "_w8"}, {cout8, sum8}, e8);
        end
    endtask

    // Drive one cycle of operands, push expectations, and compare one cycle later.
    task automatic step(input logic rst, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] a8v, input logic [7:0] b8v, input string tag);
        rst_n = rst;
        a4 = av;
        b4 = bv;
        a8 = a8v;
        b8 = b8v;
        q4.push_back(rst ? ({1'b0, av} + {1'b0, bv}) : 5'd0);
        q8.push_back(rst ? ({1'b0, a8v} + {1'b0, b8v}) : 9'd0);
        @(posedge clk);
        #1;
        pop_check(tag, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        last4 = '0;

        step(1'b0, 4'd9, 4'd9, 8'd77, 8'd200, "reset_clear");
        step(1'b1, 4'd9, 4'd9, 8'd77, 8'd200, "reset_release");

        step(1'b1, 4'd15, 4'd1,  8'd255,  8'd1,    "c15p1");
        step(1'b1, 4'd15, 4'd15, 8'h0F,   8'h01,   "c15p15");
        step(1'b1, 4'd8,  4'd7,  8'hF0,   8'h10,   "c8p7");
        step(1'b1, 4'd0,  4'd0,  8'hFF,   8'hFF,   "zero");

        // Exhaustive 4-bit sweep with a one-cycle reset pulse in the middle.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            step((i != 100), iv[7:4], iv[3:0], 8'($urandom), 8'($urandom),
                 (i == 100) ? "sweep_rst" : (i == 101) ? "sweep_resume" : "sweep");
        end

        // Hold: operands swapped on the falling edge must not disturb the outputs.
        rst_n = 1'b1;
        a4 = 4'd3; b4 = 4'd4; a8 = 8'd1; b8 = 8'd2;
        q4.push_back(5'd7);
        q8.push_back(9'd3);
        @(posedge clk);
        #1;
        pop_check("hold_first", 1'b1);
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd6; a8 = 8'd10; b8 = 8'd20;
        q4.push_back(5'd11);
        q8.push_back(9'd30);
        #1;
        check4("hold_mid", {cout4, sum4}, last4);
        @(posedge clk);
        #1;
        pop_check("hold_next", 1'b1);

        // Reset pulsed between edges has no effect.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check4("rst_between", {cout4, sum4}, last4);
        rst_n = 1'b1;
        step(1'b1, 4'd12, 4'd9, 8'hAB, 8'h55, "after_glitch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
